// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC register, next-PC selection and the IF/ID
// pipeline register, plus saturating stall/flush event counters for debug.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             IF_Flush,
    input  logic             PCSrc,
    input  logic             InstSrc,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      InstMemData,
    output logic [31:0]      InstMemAddr,
    output logic [31:0]      IF_ID_Inst,
    output logic [31:0]      IF_ID_PC4,
    output logic             IF_ID_Valid,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      if_inst_q, if_inst_d;
    logic [31:0]      if_pc4_q, if_pc4_d;
    logic             if_valid_q, if_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic        flush_eff;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        pc4         = pc_q + 32'd4;
        // The jump being taken sits in ID, so its target comes from IF/ID.
        jump_target = {if_pc4_q[31:28], if_inst_q[25:0], 2'b00};
        // A stalled ID instruction must survive, so flushes need IF_ID_Write.
        flush_eff   = (IF_Flush | InstSrc) & IF_ID_Write;

        pc_d = pc_q;
        if (PCWrite) begin
            if (InstSrc)     pc_d = jump_target;
            else if (PCSrc)  pc_d = BranchTarget;
            else             pc_d = pc4;
        end

        if_inst_d  = if_inst_q;
        if_pc4_d   = if_pc4_q;
        if_valid_d = if_valid_q;
        if (IF_ID_Write) begin
            if (flush_eff) begin
                if_inst_d  = NOP_INST;
                if_pc4_d   = 32'd0;
                if_valid_d = 1'b0;
            end else begin
                if_inst_d  = InstMemData;
                if_pc4_d   = pc4;
                if_valid_d = 1'b1;
            end
        end

        stall_cnt_d = PCWrite ? stall_cnt_q : sat_inc(stall_cnt_q);
        flush_cnt_d = flush_eff ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            if_inst_q   <= NOP_INST;
            if_pc4_q    <= 32'd0;
            if_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            if_inst_q   <= if_inst_d;
            if_pc4_q    <= if_pc4_d;
            if_valid_q  <= if_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign InstMemAddr = pc_q;
    assign IF_ID_Inst  = if_inst_q;
    assign IF_ID_PC4   = if_pc4_q;
    assign IF_ID_Valid = if_valid_q;
    assign StallCount  = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control traffic,
// all compared against a behavioural model of the fetch stage.
module tb_fetch_stage;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             PCWrite, IF_ID_Write, IF_Flush, PCSrc, InstSrc;
    logic [31:0]      BranchTarget;
    logic [31:0]      InstMemData;
    logic [31:0]      InstMemAddr, IF_ID_Inst, IF_ID_PC4;
    logic             IF_ID_Valid;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0]      m_pc, m_inst, m_pc4;
    logic             m_valid;
    logic [CNT_W-1:0] m_stall, m_flush;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .CNT_W   (CNT_W),
        .NOP_INST(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCWrite     (PCWrite),
        .IF_ID_Write (IF_ID_Write),
        .IF_Flush    (IF_Flush),
        .PCSrc       (PCSrc),
        .InstSrc     (InstSrc),
        .BranchTarget(BranchTarget),
        .InstMemData (InstMemData),
        .InstMemAddr (InstMemAddr),
        .IF_ID_Inst  (IF_ID_Inst),
        .IF_ID_PC4   (IF_ID_PC4),
        .IF_ID_Valid (IF_ID_Valid),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h1000_0004) return 32'h0800_0020;
        return 32'h2000_0000 + (addr >> 2);
    endfunction

    assign InstMemData = mem_word(InstMemAddr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_stall = '0; m_flush = '0;
    endtask

    // One clock edge of the fetch stage, from its rules, using current inputs.
    task automatic model_step();
        logic [31:0] seq, jt, fetched;
        logic        squash;
        seq     = m_pc + 32'd4;
        jt      = {m_pc4[31:28], m_inst[25:0], 2'b00};
        fetched = mem_word(m_pc);
        squash  = (IF_Flush || InstSrc) && IF_ID_Write;
        if (!PCWrite && m_stall != CNT_MAX) m_stall = m_stall + 1;
        if (squash && m_flush != CNT_MAX) m_flush = m_flush + 1;
        if (IF_ID_Write) begin
            if (squash) begin m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; end
            else        begin m_inst = fetched; m_pc4 = seq; m_valid = 1'b1; end
        end
        if (PCWrite) m_pc = InstSrc ? jt : (PCSrc ? BranchTarget : seq);
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".addr"},  InstMemAddr, m_pc);
        check_eq({tag, ".inst"},  IF_ID_Inst,  m_inst);
        check_eq({tag, ".pc4"},   IF_ID_PC4,   m_pc4);
        check_eq({tag, ".valid"}, {31'b0, IF_ID_Valid}, {31'b0, m_valid});
        check_eq({tag, ".stall"}, {16'b0, StallCount}, {16'b0, m_stall});
        check_eq({tag, ".flush"}, {16'b0, FlushCount}, {16'b0, m_flush});
    endtask

    task automatic set_ctl(input logic pcw, input logic ifw, input logic fl,
                           input logic ps, input logic is, input logic [31:0] bt);
        PCWrite = pcw; IF_ID_Write = ifw; IF_Flush = fl; PCSrc = ps; InstSrc = is;
        BranchTarget = bt;
    endtask

    task automatic cycle(input string tag, input bit do_cmp);
        model_step();
        @(posedge clk);
        #1;
        if (do_cmp) compare_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".addr"},  InstMemAddr, 32'h0);
        check_eq({tag, ".inst"},  IF_ID_Inst, 32'h0);
        check_eq({tag, ".pc4"},   IF_ID_PC4, 32'h0);
        check_eq({tag, ".valid"}, {31'b0, IF_ID_Valid}, 32'h0);
        check_eq({tag, ".stall"}, {16'b0, StallCount}, 32'h0);
        check_eq({tag, ".flush"}, {16'b0, FlushCount}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_ctl(1, 1, 0, 0, 0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Sequential fetch
        for (int i = 0; i < 4; i++) cycle("seq", 1);
        check_eq("seq.addr_10", InstMemAddr, 32'h10);
        check_eq("seq.inst_0c", IF_ID_Inst, 32'h2000_0003);
        check_eq("seq.pc4_10", IF_ID_PC4, 32'h10);

        // Load-use stall
        set_ctl(0, 0, 0, 0, 0, 32'h0);
        cycle("stall", 1);
        cycle("stall", 1);
        check_eq("stall.addr", InstMemAddr, 32'h10);
        check_eq("stall.inst", IF_ID_Inst, 32'h2000_0003);
        check_eq("stall.cnt", {16'b0, StallCount}, 32'd2);
        set_ctl(1, 1, 0, 0, 0, 32'h0);
        cycle("resume", 1);
        check_eq("resume.inst", IF_ID_Inst, 32'h2000_0004);
        check_eq("resume.addr", InstMemAddr, 32'h14);

        // Taken branch
        set_ctl(1, 1, 1, 1, 0, 32'h40);
        cycle("br", 1);
        check_eq("br.addr", InstMemAddr, 32'h40);
        check_eq("br.valid", {31'b0, IF_ID_Valid}, 32'h0);
        check_eq("br.inst", IF_ID_Inst, 32'h0);
        check_eq("br.flush", {16'b0, FlushCount}, 32'd1);
        set_ctl(1, 1, 0, 0, 0, 32'h0);
        cycle("br2", 1);
        check_eq("br2.pc4", IF_ID_PC4, 32'h44);
        check_eq("br2.inst", IF_ID_Inst, 32'h2000_0010);

        // Jump, with a simultaneous branch request that must lose
        set_ctl(1, 1, 1, 1, 0, 32'h1000_0004);
        cycle("jsetup", 1);
        set_ctl(1, 1, 0, 0, 0, 32'h0);
        cycle("jsetup", 1);
        check_eq("jmp.pre_inst", IF_ID_Inst, 32'h0800_0020);
        check_eq("jmp.pre_pc4", IF_ID_PC4, 32'h1000_0008);
        set_ctl(1, 1, 0, 1, 1, 32'h99C);
        cycle("jmp", 1);
        check_eq("jmp.addr", InstMemAddr, 32'h1000_0080);
        check_eq("jmp.valid", {31'b0, IF_ID_Valid}, 32'h0);
        check_eq("jmp.flush", {16'b0, FlushCount}, 32'd3);

        // Flush request while fully stalled is ignored
        set_ctl(0, 0, 1, 1, 0, 32'h200);
        cycle("fstall", 1);
        check_eq("fstall.addr", InstMemAddr, 32'h1000_0080);
        check_eq("fstall.flush", {16'b0, FlushCount}, 32'd3);
        check_eq("fstall.stall", {16'b0, StallCount}, 32'd3);

        // Randomized control traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] bt;
            bt = $urandom();
            bt[1:0] = 2'b00;
            set_ctl($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 7) == 0, bt);
            cycle("rand", 1);
        end

        // PC wrap-around
        set_ctl(1, 1, 1, 1, 0, 32'hFFFF_FFFC);
        cycle("wrap", 1);
        set_ctl(1, 1, 0, 0, 0, 32'h0);
        cycle("wrap", 1);
        check_eq("wrap.addr", InstMemAddr, 32'h0);
        check_eq("wrap.pc4", IF_ID_PC4, 32'h0);
        check_eq("wrap.inst", IF_ID_Inst, 32'h5FFF_FFFF);

        // Stall counter saturation
        set_ctl(0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 65540; i++) cycle("sat", 0);
        compare_all("sat");
        check_eq("sat.stall", {16'b0, StallCount}, 32'h0000_FFFF);
        cycle("sat", 1);
        check_eq("sat.hold", {16'b0, StallCount}, 32'h0000_FFFF);

        // Asynchronous reset between edges
        set_ctl(1, 1, 0, 0, 0, 32'h0);
        cycle("pre_rst", 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        model_reset();
        rst_n = 1'b1;
        cycle("post_rst", 1);
        check_eq("post_rst.addr", InstMemAddr, 32'h4);
        check_eq("post_rst.inst", IF_ID_Inst, 32'h2000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
